// File: rtl/accum_unit.sv
// 16-bit running-sum accumulator with a five-chain scan path through the accumulator register.
// S and scan_out* are taken straight from the register, so W never reaches S combinationally.
module accum_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] W,
  output logic [15:0] S,
  input  logic        scan_in0,
  input  logic        scan_in1,
  input  logic        scan_in2,
  input  logic        scan_in3,
  input  logic        scan_in4,
  input  logic        scan_enable,
  input  logic        test_mode,
  output logic        scan_out0,
  output logic        scan_out1,
  output logic        scan_out2,
  output logic        scan_out3,
  output logic        scan_out4
);

  logic [15:0] acc_q;
  logic [15:0] acc_d;
  logic [15:0] sum;
  logic [15:0] shift_val;

  // test_mode is a DFT marker only; it is deliberately not decoded anywhere
  logic unused_test_mode;
  assign unused_test_mode = test_mode;

  // The only adder: modulo-2^16 wrap on overflow, with no flag
  assign sum = acc_q + W;

  // Each chain moves from its low bit toward its high bit; the high bit feeds scan_out
  assign shift_val = {acc_q[14:13], scan_in4,
                      acc_q[11:10], scan_in3,
                      acc_q[8:7],   scan_in2,
                      acc_q[5:4],   scan_in1,
                      acc_q[2:0],   scan_in0};

  always_comb begin
    acc_d = acc_q;
    if (reset)            acc_d = 16'h0000;
    else if (scan_enable) acc_d = shift_val;
    else                  acc_d = sum;
  end

  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

  assign S         = acc_q;
  assign scan_out0 = acc_q[3];
  assign scan_out1 = acc_q[6];
  assign scan_out2 = acc_q[9];
  assign scan_out3 = acc_q[12];
  assign scan_out4 = acc_q[15];

endmodule

// File: tb/tb_accum_unit.sv
// Scoreboard bench for accum_unit: expectations are queued as each cycle is driven, then popped and compared after the edge.
module tb_accum_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] W = 16'h0000;
  logic [15:0] S;
  logic [4:0]  si = 5'b0;
  logic        scan_enable = 1'b0;
  logic        test_mode = 1'b0;
  logic [4:0]  so;

  typedef struct packed {
    logic [15:0] s;
    logic [4:0]  so;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  logic [15:0] model  = 16'h0000;

  always #5 clk = ~clk;

  accum_unit dut (
    .clk(clk), .reset(reset), .W(W), .S(S),
    .scan_in0(si[0]), .scan_in1(si[1]), .scan_in2(si[2]), .scan_in3(si[3]), .scan_in4(si[4]),
    .scan_enable(scan_enable), .test_mode(test_mode),
    .scan_out0(so[0]), .scan_out1(so[1]), .scan_out2(so[2]), .scan_out3(so[3]), .scan_out4(so[4])
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, obs, exp_v);
  endtask

  function automatic logic [4:0] so_of(input logic [15:0] v);
    return {v[15], v[12], v[9], v[6], v[3]};
  endfunction

  // Drive one cycle, push the expectation, clock it, then pop and compare
  task automatic cyc(input string tag, input logic rst, input logic se, input logic tm,
                     input logic [15:0] w, input logic [4:0] s_in, input logic [15:0] exp_s);
    exp_t e;
    reset = rst; scan_enable = se; test_mode = tm; W = w; si = s_in;
    sb_q.push_back('{s: exp_s, so: so_of(exp_s)});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({tag, ".S"}, S, e.s);
    chk({tag, ".so"}, {11'b0, so}, {11'b0, e.so});
  endtask

  // Independent model: per-chain bit tables rather than a packed concatenation
  function automatic logic [15:0] next_model(input logic [15:0] m, input logic rst, input logic se,
                                             input logic [15:0] w, input logic [4:0] s_in);
    int lo[5] = '{0, 4, 7, 10, 13};
    int hi[5] = '{3, 6, 9, 12, 15};
    logic [15:0] r;
    r = m;
    if (rst) r = 16'h0000;
    else if (se) begin
      for (int c = 0; c < 5; c++) begin
        for (int b = hi[c]; b > lo[c]; b--) r[b] = m[b-1];
        r[lo[c]] = s_in[c];
      end
    end else r = m + w;
    return r;
  endfunction

  initial begin
    // Reset with a nonzero addend present
    cyc("rst0", 1, 0, 0, 16'h1234, 5'h00, 16'h0000);
    cyc("rst1", 1, 0, 0, 16'h1234, 5'h00, 16'h0000);

    // Accumulation, including a negative addend
    cyc("acc0", 0, 0, 0, 16'h0003, 5'h00, 16'h0003);
    cyc("acc1", 0, 0, 0, 16'h0005, 5'h00, 16'h0008);
    cyc("acc2", 0, 0, 0, 16'hFFFE, 5'h00, 16'h0006);
    cyc("hold", 0, 0, 0, 16'h0000, 5'h1F, 16'h0006);

    // Wrap around the signed and unsigned boundaries
    cyc("wrst", 1, 0, 0, 16'h0000, 5'h00, 16'h0000);
    cyc("w7ff", 0, 0, 0, 16'h7FFF, 5'h00, 16'h7FFF);
    cyc("w800", 0, 0, 0, 16'h0001, 5'h00, 16'h8000);
    cyc("wrap", 0, 0, 0, 16'h8000, 5'h00, 16'h0000);

    // Reset mid-accumulation discards the pending sum
    cyc("mA0",  0, 0, 0, 16'h00A0, 5'h00, 16'h00A0);
    cyc("mrst", 1, 0, 0, 16'h0010, 5'h00, 16'h0000);
    cyc("mpost",0, 0, 0, 16'h0010, 5'h00, 16'h0010);

    // Reset beats scan in the same cycle
    cyc("rscan",1, 1, 0, 16'h5555, 5'h1F, 16'h0000);

    // Scan fill with all ones, W ignored
    cyc("sc0", 0, 1, 0, 16'h1111, 5'h1F, 16'h2491);
    cyc("sc1", 0, 1, 0, 16'h2222, 5'h1F, 16'h6DB3);
    cyc("sc2", 0, 1, 0, 16'h3333, 5'h1F, 16'hFFF7);
    cyc("sc3", 0, 1, 0, 16'h4444, 5'h1F, 16'hFFFF);
    cyc("scF", 0, 0, 0, 16'h0001, 5'h00, 16'h0000);

    // Single marker on chain0 walks toward scan_out0, scan_in ignored in functional mode
    cyc("mk0", 0, 0, 0, 16'h0000, 5'h1F, 16'h0000);
    cyc("mk1", 0, 1, 0, 16'hFFFF, 5'h01, 16'h0001);
    cyc("mk2", 0, 1, 0, 16'hFFFF, 5'h00, 16'h0002);
    cyc("mk3", 0, 1, 0, 16'hFFFF, 5'h00, 16'h0004);
    cyc("mk4", 0, 1, 0, 16'hFFFF, 5'h00, 16'h0008);

    // test_mode has no effect on accumulation
    cyc("trst", 1, 0, 1, 16'h0000, 5'h00, 16'h0000);
    cyc("tac0", 0, 0, 1, 16'h0003, 5'h00, 16'h0003);
    cyc("tac1", 0, 0, 1, 16'h0005, 5'h00, 16'h0008);
    cyc("tac2", 0, 0, 1, 16'hFFFE, 5'h00, 16'h0006);

    // Randomized mix against the bit-table model
    model = 16'h0006;
    for (int i = 0; i < 300; i++) begin
      logic        r_rst, r_se, r_tm;
      logic [15:0] r_w;
      logic [4:0]  r_si;
      r_rst = ($urandom_range(0, 19) == 0);
      r_se  = ($urandom_range(0, 2) == 0);
      r_tm  = 1'($urandom);
      r_w   = 16'($urandom);
      r_si  = 5'($urandom);
      model = next_model(model, r_rst, r_se, r_w, r_si);
      cyc("rnd", r_rst, r_se, r_tm, r_w, r_si, model);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
